mod_issue: RTL and testbench
============================

# mod_issue

Issue/writeback controller sitting directly upstream of the multi-cycle `mod` unit in the MIPS ALU. It accepts one remainder request (A % B plus destination register) over a valid/ready handshake, launches the `mod` unit, and waits for its `We` pulse. It then captures the result and holds it for the register-file writeback port until that port accepts it. It also bypasses the unit for B == 0, which would otherwise never terminate, and records the latency of the last operation.

## Interface
- `WIDTH`, 32, operand/result width
- `REG_ADDR_W`, 5, destination register index width
- `LAT_W`, 16, latency counter width
- `Clk  in  1  clock, all state updates on rising edge`
- `Reset  in  1  synchronous, active-high reset`
- `Req_Valid  in  1  request present`
- `Req_Ready  out  1  controller can accept a request`
- `Req_A  in  WIDTH  dividend`
- `Req_B  in  WIDTH  divisor`
- `Req_Rd  in  REG_ADDR_W  destination register`
- `Mod_En  out  1  enable to the mod unit`
- `Mod_A  out  WIDTH  registered dividend to the mod unit`
- `Mod_B  out  WIDTH  registered divisor to the mod unit`
- `Mod_Result  in  WIDTH  mod unit result, valid when Mod_We = 1`
- `Mod_We  in  1  one-cycle completion pulse from the mod unit`
- `Wb_Valid  out  1  writeback data present`
- `Wb_Ready  in  1  register file accepts writeback`
- `Wb_Data  out  WIDTH  remainder`
- `Wb_Rd  out  REG_ADDR_W  destination register`
- `Wb_Div_Zero  out  1  result came from the B == 0 bypass`
- `Last_Lat  out  LAT_W  cycles from accept to Wb_Valid for the last op, saturating`

## Operation
- States: IDLE, RUN, HOLD.
- `Req_Ready` = (state == IDLE). `Wb_Valid` = (state == HOLD). `Mod_En` = (state == RUN).
- IDLE, on `Req_Valid`:
  - Register A, B and Rd.
  - If Req_B != 0: go to RUN.
  - If Req_B == 0: load `Wb_Data` = Req_A, set `Wb_Div_Zero` = 1, go to HOLD. `Mod_En` is never raised.
- RUN:
  - `Mod_A` and `Mod_B` stay stable for the whole state.
  - On `Mod_We` = 1: capture `Mod_Result` into `Wb_Data`, clear `Wb_Div_Zero`, go to HOLD.
- HOLD:
  - `Wb_Data`, `Wb_Rd` and `Wb_Div_Zero` stay stable until the handshake completes.
  - On `Wb_Ready` = 1: go to IDLE.
- `Mod_We` is ignored outside RUN (stray pulses have no effect).
- `Req_Valid` is ignored outside IDLE. A request cannot be accepted in the same cycle as the HOLD handshake.
- Rd = 0 is processed normally; discarding writes to register 0 is the register file's job.
- Latency counter:
  - Clears to 1 on accept and increments each cycle in RUN, saturating at 2^LAT_W−1.
  - Copied to `Last_Lat` on entry to HOLD.
- Remainder semantics are unsigned and computed entirely by the mod unit; this block does no arithmetic beyond the zero compare and the counter.

## Timing
- Reset values:
  - state = IDLE, so `Req_Ready` = 1, `Wb_Valid` = 0, `Mod_En` = 0.
  - `Mod_A`, `Mod_B`, `Wb_Data`, `Wb_Rd` = 0; `Wb_Div_Zero` = 0; `Last_Lat` = 0.
- Reset asserted in any state aborts the operation. `Mod_En` is low the cycle after the reset edge, and the result is lost. The mod unit shares `Reset`.
- Accept at edge N (Req_Valid & Req_Ready sampled high):
  - Normal op: `Mod_En` is high from cycle N+1.
  - Mod_We sampled high at edge M: `Mod_En` is low and `Wb_Valid` high from M+1. `Last_Lat` = M−N+1.
- B == 0: `Wb_Valid` is high in cycle N+1 and `Last_Lat` = 1.
- Writeback accepted at edge K: `Req_Ready` is high from K+1. Minimum request-to-request spacing is 3 cycles for normal ops and 2 for bypass.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mod_pkg` holds: `WIDTH`, `REG_ADDR_W`, `LAT_W` defaults, and the state encoding (IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2).
- One sub-module, `sat_cnt`: a LAT_W saturating counter with load-1 and increment inputs.
- The FSM and datapath registers live in `mod_issue`.

## Test plan
- A = 17, B = 5, bench mod model raises We 4 cycles after En:
  - Expect Wb_Data = 2, Wb_Rd = requested Rd, Wb_Div_Zero = 0, Last_Lat = 5.
  - Mod_A and Mod_B stay stable throughout RUN.
- A = 0x1234, B = 0:
  - Mod_En is never high.
  - Wb_Valid one cycle after accept, with Wb_Data = 0x1234, Wb_Div_Zero = 1, Last_Lat = 1.
- A = 100, B = 7 with Wb_Ready held low 3 cycles:
  - Wb_Data = 2 held stable the whole time.
  - Req_Ready stays 0 until the cycle after Wb_Ready = 1.
- Reset asserted in the 2nd RUN cycle of A = 9, B = 4:
  - Next cycle: Mod_En = 0, Wb_Valid = 0, Req_Ready = 1.
  - A Mod_We pulse arriving afterwards produces no writeback.
- Stray Mod_We pulse in IDLE followed by request A = 10, B = 3:
  - Result 1 is produced only after the real We.
  - Req_Valid toggling during RUN and HOLD is ignored.

Source files
------------

// File: rtl/mod_pkg.sv
// Shared defaults and FSM encoding for the remainder issue/writeback controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mod_pkg;

    localparam int WIDTH      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int LAT_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with a load-to-one input, used to time issue-to-writeback latency.
// Latency: registered count; cnt_nxt_o is the combinational next value.
// Backpressure: none; load_i has priority over inc_i.
//
// Ports:
//   clk_i, rst_i  rising-edge clock, synchronous active-high reset
//   load_i        force the count to 1 at the next edge
//   inc_i         add 1 at the next edge, sticking at all-ones
//   cnt_nxt_o     value the counter takes at the next edge
module sat_cnt #(
    parameter int LAT_W = mod_pkg::LAT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [LAT_W-1:0] cnt_nxt_o
);

    localparam logic [LAT_W-1:0] CNT_MAX = '1;

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LAT_W'(1);
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + LAT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Exposing the next value lets a capturing register include the
    // increment of the very edge on which it captures.
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/mod_issue.sv
// Issue/writeback controller in front of the multi-cycle mod unit; bypasses B == 0.
// Latency: accept-to-Wb_Valid is 1 cycle for B == 0, else (mod unit cycles + 1); all outputs registered/state-decoded.
// Backpressure: one op in flight; Req_Ready only in IDLE, result held in HOLD until Wb_Ready.
//
// Ports:
//   Clk, Reset                         clock, synchronous active-high reset
//   Req_Valid/Req_Ready, Req_A/B/Rd    request handshake and operands
//   Mod_En, Mod_A/B, Mod_Result/We     launch and completion interface of the mod unit
//   Wb_Valid/Wb_Ready, Wb_Data/Rd      register-file writeback handshake
//   Wb_Div_Zero                        result is the dividend passed through for B == 0
//   Last_Lat                           accept-to-writeback cycles of the last op, saturating
module mod_issue #(
    parameter int WIDTH      = mod_pkg::WIDTH,
    parameter int REG_ADDR_W = mod_pkg::REG_ADDR_W,
    parameter int LAT_W      = mod_pkg::LAT_W
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req_Valid,
    output logic                  Req_Ready,
    input  logic [WIDTH-1:0]      Req_A,
    input  logic [WIDTH-1:0]      Req_B,
    input  logic [REG_ADDR_W-1:0] Req_Rd,
    output logic                  Mod_En,
    output logic [WIDTH-1:0]      Mod_A,
    output logic [WIDTH-1:0]      Mod_B,
    input  logic [WIDTH-1:0]      Mod_Result,
    input  logic                  Mod_We,
    output logic                  Wb_Valid,
    input  logic                  Wb_Ready,
    output logic [WIDTH-1:0]      Wb_Data,
    output logic [REG_ADDR_W-1:0] Wb_Rd,
    output logic                  Wb_Div_Zero,
    output logic [LAT_W-1:0]      Last_Lat
);

    import mod_pkg::*;

    state_t                  state_q,    state_d;
    logic [WIDTH-1:0]        mod_a_q,    mod_a_d;
    logic [WIDTH-1:0]        mod_b_q,    mod_b_d;
    logic [WIDTH-1:0]        wb_data_q,  wb_data_d;
    logic [REG_ADDR_W-1:0]   wb_rd_q,    wb_rd_d;
    logic                    wb_dz_q,    wb_dz_d;
    logic [LAT_W-1:0]        last_lat_q, last_lat_d;

    logic                    lat_load;
    logic                    lat_inc;
    logic [LAT_W-1:0]        lat_nxt;

    sat_cnt #(
        .LAT_W (LAT_W)
    ) u_lat_cnt (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .load_i    (lat_load),
        .inc_i     (lat_inc),
        .cnt_nxt_o (lat_nxt)
    );

    always_comb begin
        state_d    = state_q;
        mod_a_d    = mod_a_q;
        mod_b_d    = mod_b_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_dz_d    = wb_dz_q;
        last_lat_d = last_lat_q;
        lat_load   = 1'b0;
        lat_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req_Valid) begin
                    mod_a_d  = Req_A;
                    mod_b_d  = Req_B;
                    wb_rd_d  = Req_Rd;
                    lat_load = 1'b1;
                    if (Req_B != '0) begin
                        state_d = RUN;
                    end else begin
                        // The mod unit never terminates on a zero divisor,
                        // so the dividend is returned without launching it.
                        wb_data_d  = Req_A;
                        wb_dz_d    = 1'b1;
                        last_lat_d = lat_nxt;
                        state_d    = HOLD;
                    end
                end
            end
            RUN: begin
                lat_inc = 1'b1;
                if (Mod_We) begin
                    wb_data_d  = Mod_Result;
                    wb_dz_d    = 1'b0;
                    // lat_nxt already counts the completion edge itself.
                    last_lat_d = lat_nxt;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (Wb_Ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            mod_a_q    <= '0;
            mod_b_q    <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_dz_q    <= 1'b0;
            last_lat_q <= '0;
        end else begin
            state_q    <= state_d;
            mod_a_q    <= mod_a_d;
            mod_b_q    <= mod_b_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_dz_q    <= wb_dz_d;
            last_lat_q <= last_lat_d;
        end
    end

    assign Req_Ready   = (state_q == IDLE);
    assign Mod_En      = (state_q == RUN);
    assign Wb_Valid    = (state_q == HOLD);
    assign Mod_A       = mod_a_q;
    assign Mod_B       = mod_b_q;
    assign Wb_Data     = wb_data_q;
    assign Wb_Rd       = wb_rd_q;
    assign Wb_Div_Zero = wb_dz_q;
    assign Last_Lat    = last_lat_q;

endmodule

// File: tb/tb_mod_issue.sv
module tb_mod_issue;

    localparam int W   = 32;
    localparam int RW  = 5;
    localparam int LW  = 4;
    localparam int LAT_MAX = (1 << LW) - 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Req_Valid;
    logic          Req_Ready;
    logic [W-1:0]  Req_A;
    logic [W-1:0]  Req_B;
    logic [RW-1:0] Req_Rd;
    logic          Mod_En;
    logic [W-1:0]  Mod_A;
    logic [W-1:0]  Mod_B;
    logic [W-1:0]  Mod_Result;
    logic          Mod_We;
    logic          Wb_Valid;
    logic          Wb_Ready;
    logic [W-1:0]  Wb_Data;
    logic [RW-1:0] Wb_Rd;
    logic          Wb_Div_Zero;
    logic [LW-1:0] Last_Lat;

    always #5 Clk = ~Clk;

    mod_issue #(
        .WIDTH      (W),
        .REG_ADDR_W (RW),
        .LAT_W      (LW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req_Valid   (Req_Valid),
        .Req_Ready   (Req_Ready),
        .Req_A       (Req_A),
        .Req_B       (Req_B),
        .Req_Rd      (Req_Rd),
        .Mod_En      (Mod_En),
        .Mod_A       (Mod_A),
        .Mod_B       (Mod_B),
        .Mod_Result  (Mod_Result),
        .Mod_We      (Mod_We),
        .Wb_Valid    (Wb_Valid),
        .Wb_Ready    (Wb_Ready),
        .Wb_Data     (Wb_Data),
        .Wb_Rd       (Wb_Rd),
        .Wb_Div_Zero (Wb_Div_Zero),
        .Last_Lat    (Last_Lat)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [RW-1:0] rd;
        logic          dz;
        logic [LW-1:0] lat;
        int            cyc;
        int            en_cycles;
    } exp_t;

    exp_t scb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // mod unit emulation controls
    logic [W-1:0] cur_a = '0;
    logic [W-1:0] cur_b = '0;
    int mod_delay  = 1;
    int stray_cnt  = 0;
    int stray_done = 0;
    int total_en   = 0;

    // monitor state shared with stimulus
    int hold_cycles = 0;
    int hs_count    = 0;
    int wb_hold     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    initial forever begin
        @(posedge Clk);
        cyc = cyc + 1;
    end

    // Behavioural mod unit: raises We after mod_delay enabled cycles and
    // fires requested stray pulses whenever it is not enabled.
    initial begin
        int run_cnt;
        run_cnt    = 0;
        Mod_We     = 1'b0;
        Mod_Result = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                run_cnt = 0;
                Mod_We  = 1'b0;
            end else if (Mod_En) begin
                total_en = total_en + 1;
                run_cnt  = run_cnt + 1;
                chk("mod_a_stable", 64'(Mod_A), 64'(cur_a));
                chk("mod_b_stable", 64'(Mod_B), 64'(cur_b));
                if (run_cnt == mod_delay) begin
                    Mod_We     = 1'b1;
                    Mod_Result = (Mod_B != 0) ? (Mod_A % Mod_B) : '0;
                end else begin
                    Mod_We = 1'b0;
                end
            end else begin
                run_cnt = 0;
                if (stray_done != stray_cnt) begin
                    Mod_We     = 1'b1;
                    Mod_Result = $urandom;
                    stray_done = stray_done + 1;
                end else begin
                    Mod_We = 1'b0;
                end
            end
        end
    end

    // Writeback monitor: pops the scoreboard on each new Wb_Valid.
    initial begin
        exp_t e;
        bit   in_hold;
        bit   bogus;
        bit   post_hs;
        int   en_base;
        in_hold = 0;
        bogus   = 0;
        post_hs = 0;
        en_base = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                in_hold     = 0;
                post_hs     = 0;
                hold_cycles = 0;
                en_base     = total_en;
            end else if (Wb_Valid) begin
                if (!in_hold) begin
                    if (scb.size() == 0) begin
                        chk("unexpected_writeback", 64'(Wb_Valid), 64'd0);
                        bogus = 1;
                    end else begin
                        e     = scb.pop_front();
                        bogus = 0;
                        chk("wb_data",        64'(Wb_Data),     64'(e.data));
                        chk("wb_rd",          64'(Wb_Rd),       64'(e.rd));
                        chk("wb_div_zero",    64'(Wb_Div_Zero), 64'(e.dz));
                        chk("last_lat",       64'(Last_Lat),    64'(e.lat));
                        chk("wb_valid_cycle", 64'(cyc),         64'(e.cyc));
                        chk("mod_en_cycles",  64'(total_en - en_base), 64'(e.en_cycles));
                    end
                    in_hold = 1;
                end else if (!bogus) begin
                    chk("wb_data_held", 64'(Wb_Data),     64'(e.data));
                    chk("wb_rd_held",   64'(Wb_Rd),       64'(e.rd));
                    chk("wb_dz_held",   64'(Wb_Div_Zero), 64'(e.dz));
                end
                chk("req_ready_in_hold", 64'(Req_Ready), 64'd0);
                hold_cycles = hold_cycles + 1;
                if (Wb_Ready) begin
                    hs_count    = hs_count + 1;
                    in_hold     = 0;
                    hold_cycles = 0;
                    post_hs     = 1;
                    en_base     = total_en;
                end
            end else if (post_hs) begin
                chk("req_ready_after_wb", 64'(Req_Ready), 64'd1);
                post_hs = 0;
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RW-1:0] rd, input int d, input int hold);
        exp_t e;
        int   acc_edge;
        int   target;
        bit   got;
        @(posedge Clk); #1;
        Req_A     = a;
        Req_B     = b;
        Req_Rd    = rd;
        Req_Valid = 1'b1;
        cur_a     = a;
        cur_b     = b;
        mod_delay = d;
        wb_hold   = hold;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Req_Ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("accept_timeout", 64'd0, 64'd1);
            Req_Valid = 1'b0;
            return;
        end
        acc_edge    = cyc + 1;
        e.data      = (b == 0) ? a : (a % b);
        e.rd        = rd;
        e.dz        = (b == 0);
        e.lat       = (b == 0) ? LW'(1) : LW'(((d + 1) > LAT_MAX) ? LAT_MAX : (d + 1));
        e.cyc       = (b == 0) ? acc_edge : (acc_edge + d);
        e.en_cycles = (b == 0) ? 0 : d;
        target      = hs_count + 1;
        scb.push_back(e);
        @(posedge Clk); #1;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            if (hs_count >= target) begin
                got = 1;
                break;
            end
            // Request noise while busy must be ignored.
            Req_Valid = 1'($urandom_range(0, 1));
            Req_A     = $urandom;
            Req_B     = W'($urandom_range(0, 3));
            Req_Rd    = RW'($urandom);
            Wb_Ready  = (hold_cycles >= wb_hold);
            @(posedge Clk); #1;
        end
        Req_Valid = 1'b0;
        Wb_Ready  = 1'b0;
        if (!got) chk("wb_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit got;
        Reset     = 1'b1;
        Req_Valid = 1'b0;
        Req_A     = '0;
        Req_B     = '0;
        Req_Rd    = '0;
        Wb_Ready  = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_req_ready",   64'(Req_Ready),   64'd1);
        chk("rst_wb_valid",    64'(Wb_Valid),    64'd0);
        chk("rst_mod_en",      64'(Mod_En),      64'd0);
        chk("rst_mod_a",       64'(Mod_A),       64'd0);
        chk("rst_mod_b",       64'(Mod_B),       64'd0);
        chk("rst_wb_data",     64'(Wb_Data),     64'd0);
        chk("rst_wb_rd",       64'(Wb_Rd),       64'd0);
        chk("rst_wb_div_zero", 64'(Wb_Div_Zero), 64'd0);
        chk("rst_last_lat",    64'(Last_Lat),    64'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        do_op(32'd17,     32'd5, 5'd3,  4, 0);
        do_op(32'h1234,   32'd0, 5'd7,  1, 1);
        do_op(32'd100,    32'd7, 5'd12, 2, 3);

        // Abort: reset lands during the second RUN cycle of 9 % 4.
        @(posedge Clk); #1;
        Req_A = 32'd9; Req_B = 32'd4; Req_Rd = 5'd1; Req_Valid = 1'b1;
        cur_a = 32'd9; cur_b = 32'd4; mod_delay = 50;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Req_Ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("abort_accept_timeout", 64'd0, 64'd1);
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_mod_en",    64'(Mod_En),    64'd0);
        chk("abort_wb_valid",  64'(Wb_Valid),  64'd0);
        chk("abort_req_ready", 64'(Req_Ready), 64'd1);
        chk("abort_wb_data",   64'(Wb_Data),   64'd0);
        chk("abort_last_lat",  64'(Last_Lat),  64'd0);
        stray_cnt = stray_cnt + 1;
        repeat (6) begin
            @(negedge Clk);
            chk("abort_no_wb", 64'(Wb_Valid), 64'd0);
        end

        // Stray completion in IDLE, then a real op.
        stray_cnt = stray_cnt + 1;
        repeat (3) @(negedge Clk);
        chk("stray_wb_valid",  64'(Wb_Valid),  64'd0);
        chk("stray_req_ready", 64'(Req_Ready), 64'd1);
        do_op(32'd10, 32'd3, 5'd9, 3, 1);

        // Rd = 0 is an ordinary destination.
        do_op(32'd23, 32'd6, 5'd0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            int           sel;
            ra  = $urandom;
            sel = $urandom_range(0, 4);
            if (sel == 0)      rb = '0;
            else if (sel == 1) rb = W'($urandom_range(1, 15));
            else               rb = $urandom;
            if ($urandom_range(0, 3) == 0) stray_cnt = stray_cnt + 1;
            do_op(ra, rb, RW'($urandom), $urandom_range(1, 20), $urandom_range(0, 3));
        end

        repeat (5) @(negedge Clk);
        chk("scoreboard_drained", 64'(scb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
